// File: rtl/sorted_insert_writer_if.sv
// sorted_insert_writer_if
// RAM access bus between the sorted-insert writer and a 32-word synchronous RAM.
//   rd_addr : read address (writer -> RAM)
//   rd_data : read data, valid one cycle after rd_addr (RAM -> writer)
//   wr_en   : write enable (writer -> RAM)
//   wr_addr : write address (writer -> RAM)
//   wr_data : write data (writer -> RAM)
// Modports: master = writer side, slave = RAM side.
interface sorted_insert_writer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output rd_addr,
    input  rd_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/sorted_insert_writer.sv
// sorted_insert_writer
// Inserts one value per start request into a synchronous RAM, keeping
// mem[0 .. count-1] sorted ascending. Larger entries are shifted up one slot
// (read at i-1, write at i) until the hole reaches the insertion point, then
// the key is written into the hole.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   start    : level request, accepted in IDLE
//   A        : value to insert, latched on the accepting edge
//   ram      : RAM bus (master modport): rd_addr/rd_data, wr_en/wr_addr/wr_data
//   count    : number of valid stored entries (0 .. 2**ADDR_W)
//   full     : count == 2**ADDR_W (combinational)
//   done     : insert or rejection complete; held until start drops
//   ins_addr : slot where the last accepted value was written
module sorted_insert_writer #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_W-1:0]      A,
  sorted_insert_writer_if.master ram,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   done,
  output logic [ADDR_W-1:0]      ins_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_CMP   = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [ADDR_W:0]   i_q, i_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] ins_addr_q, ins_addr_d;

  // i - 1 is both the slot being read and the next hole position after a shift.
  logic [ADDR_W:0] i_minus1;
  logic            hole_at_bottom;

  assign i_minus1       = i_q - 1'b1;
  assign hole_at_bottom = (i_minus1 == '0);

  assign count    = count_q;
  assign ins_addr = ins_addr_q;
  assign full     = (count_q == CAPACITY);

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    i_d         = i_q;
    count_d     = count_q;
    ins_addr_d  = ins_addr_q;
    ram.rd_addr = '0;
    ram.wr_en   = 1'b0;
    ram.wr_addr = '0;
    ram.wr_data = '0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d = A;
          if (full) begin
            state_d = S_DONE;
          end else if (count_q == '0) begin
            i_d     = '0;
            state_d = S_WRITE;
          end else begin
            i_d     = count_q;
            state_d = S_RD;
          end
        end
      end

      S_RD: begin
        ram.rd_addr = i_minus1[ADDR_W-1:0];
        state_d     = S_CMP;
      end

      S_CMP: begin
        // Strict compare: equal entries stay below the new key (stable insert).
        if (ram.rd_data > key_q) begin
          ram.wr_en   = 1'b1;
          ram.wr_addr = i_q[ADDR_W-1:0];
          ram.wr_data = ram.rd_data;
          i_d         = i_minus1;
          state_d     = hole_at_bottom ? S_WRITE : S_RD;
        end else begin
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        ram.wr_en   = 1'b1;
        ram.wr_addr = i_q[ADDR_W-1:0];
        ram.wr_data = key_q;
        ins_addr_d  = i_q[ADDR_W-1:0];
        count_d     = count_q + 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        done = 1'b1;
        // Wait for start to drop so a held request inserts only once.
        if (!start) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      i_q        <= '0;
      count_q    <= '0;
      ins_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      i_q        <= i_d;
      count_q    <= count_d;
      ins_addr_q <= ins_addr_d;
    end
  end

endmodule
